// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register bank, reads, repeated START,
// auto-increment with wrap and a host-side write port.
module i2c_reg_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         NUM_REGS    = 16,
  parameter int         AW          = $clog2(NUM_REGS),
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_flat,
  input  logic                  hw_we,
  input  logic [AW-1:0]         hw_addr,
  input  logic [7:0]            hw_data,
  output logic                  wr_strobe,
  output logic [AW-1:0]         wr_addr,
  output logic                  hw_collision,
  output logic                  busy
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FMAX   = CW'(FILTER_LEN - 1);
  localparam logic [AW-1:0] LAST   = AW'(NUM_REGS - 1);
  localparam logic [AW:0]   NR_HW  = (AW + 1)'(NUM_REGS);
  localparam logic [8:0]    NR_SUB = 9'(NUM_REGS);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] SUB       = 4'd3;
  localparam logic [3:0] SUB_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] RDATA     = 4'd7;
  localparam logic [3:0] RACK      = 4'd8;
  localparam logic [3:0] IGNORE    = 4'd9;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [CW-1:0]          scl_cnt, sda_cnt;
  logic                   scl_f, sda_f, scl_q, sda_q;
  logic [3:0]             state;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;
  logic [7:0]             tx;
  logic                   rw;
  logic [AW-1:0]          ptr, ptr_nxt;
  logic [7:0]             regs [NUM_REGS];

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic       commit, hw_ok, hit;
  logic [7:0] rx_byte;

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte  = {shreg, sda_f};
  assign ptr_nxt  = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign commit   = scl_rise & (state == WDATA) & (bit_cnt == 3'd7);
  assign hw_ok    = hw_we & ({1'b0, hw_addr} < NR_HW);
  assign hit      = commit & (hw_addr == ptr);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = regs[k];
  end

  // Pad synchronisers; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  // Glitch filter: accept a level only after FILTER_LEN equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[SYNC_STAGES-1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == FMAX) begin
        scl_f   <= ~scl_f;
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 1'b1;
      if (sda_sync[SYNC_STAGES-1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == FMAX) begin
        sda_f   <= ~sda_f;
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 1'b1;
    end
  end

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // Register bank: I2C commit wins over a host write to the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (hw_ok && !hit) regs[hw_addr] <= hw_data;
      if (commit) regs[ptr] <= rx_byte;
    end
  end

  // Commit and collision pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      hw_collision <= 1'b0;
    end else begin
      wr_strobe    <= commit;
      hw_collision <= hw_ok & hit;
      if (commit) wr_addr <= ptr;
    end
  end

  // Protocol FSM: bits on SCL rise, SDA drive updated on SCL fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= '0;
      rw      <= 1'b0;
      ptr     <= '0;
      busy    <= 1'b0;
      sda_oe  <= 1'b0;
    end else if (start_c) begin
      state   <= ADDR;
      bit_cnt <= '0;
      sda_oe  <= 1'b0;
    end else if (stop_c) begin
      state  <= IDLE;
      busy   <= 1'b0;
      sda_oe <= 1'b0;
    end else if (scl_rise) begin
      case (state)
        ADDR: begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == I2C_ADDR) begin
              state <= ADDR_ACK;
              rw    <= rx_byte[0];
              busy  <= 1'b1;
            end else begin
              state <= IGNORE;
              busy  <= 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          bit_cnt <= '0;
          if (rw) begin
            state <= RDATA;
            tx    <= regs[ptr];
          end else state <= SUB;
        end
        SUB: begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            if ({1'b0, rx_byte} < NR_SUB) begin
              ptr   <= rx_byte[AW-1:0];
              state <= SUB_ACK;
            end else state <= IGNORE;
          end
        end
        SUB_ACK: begin
          state   <= WDATA;
          bit_cnt <= '0;
        end
        WDATA: begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            ptr   <= ptr_nxt;
            state <= WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          state   <= WDATA;
          bit_cnt <= '0;
        end
        RDATA: begin
          tx      <= {tx[6:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state <= RACK;
        end
        RACK: begin
          if (!sda_f) begin
            ptr     <= ptr_nxt;
            tx      <= regs[ptr_nxt];
            state   <= RDATA;
            bit_cnt <= '0;
          end else state <= IGNORE;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      sda_oe <= (state == ADDR_ACK) | (state == SUB_ACK) |
                (state == WDATA_ACK) | ((state == RDATA) & ~tx[7]);
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, expected results
// queued at stimulus time and checked by separate monitor processes.
module tb_i2c_reg_target;

  localparam int Q = 10;
  localparam int H = 20;

  logic         clk = 1'b0;
  logic         rst, scl_m, sda_m, hw_we;
  logic [3:0]   hw_addr;
  logic [7:0]   hw_data;
  logic         sda_oe, wr_strobe, hw_collision, busy;
  logic [127:0] regs_flat;
  logic [3:0]   wr_addr;
  logic         sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_reg_target dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .regs_flat(regs_flat),
    .hw_we(hw_we), .hw_addr(hw_addr), .hw_data(hw_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .hw_collision(hw_collision), .busy(busy)
  );

  typedef struct { int kind; int val; } ev_t;
  typedef struct { int a; int d; } wr_t;

  ev_t exp_q[$];
  int  obs_q[$];
  wr_t exp_wr_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int col_seen = 0;
  bit watch = 0, oe_seen = 0, busy_seen = 0;
  logic [3:0] col_a;
  logic [7:0] col_d;
  ev_t e;
  wr_t w;
  int  o;
  logic s;

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic int reg_at(int k);
    return int'(regs_flat[8*k +: 8]);
  endfunction

  task automatic wt(int n);
    repeat (n) @(negedge clk);
  endtask

  // Write-commit, collision and bus-observation monitor.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_wr_q.size() == 0) chk("unexp_wr", int'(wr_addr), -1);
      else begin
        w = exp_wr_q.pop_front();
        chk("wr_addr", int'(wr_addr), w.a);
        chk("wr_data", reg_at(int'(wr_addr)), w.d);
      end
    end
    if (hw_collision) col_seen++;
    if (watch && sda_oe) oe_seen = 1;
    if (watch && busy) busy_seen = 1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) chk("unexp_obs", o, -1);
      else begin
        e = exp_q.pop_front();
        chk(e.kind == 0 ? "ack_bit" : "rd_byte", o, e.val);
      end
    end
  end

  // mode 1: SDA glitch low mid-high; mode 2: host write on commit edge
  task automatic bitx(input logic b, output logic sv, input int mode);
    wt(Q);
    sda_m = b;
    wt(Q);
    scl_m = 1'b1;
    if (mode == 1) begin
      wt(4);
      sda_m = 1'b0;
      wt(2);
      sda_m = b;
      wt(Q - 6);
    end else if (mode == 2) begin
      wt(5);
      hw_we   = 1'b1;
      hw_addr = col_a;
      hw_data = col_d;
      wt(1);
      hw_we = 1'b0;
      wt(Q - 6);
    end else wt(Q);
    sv = sda_bus;
    wt(Q);
    scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, input int ack,
                         input int mode = 0, input int mbit = -1);
    logic sv;
    exp_q.push_back('{0, ack});
    for (int i = 7; i >= 0; i--) bitx(b[i], sv, (i == mbit) ? mode : 0);
    bitx(1'b1, sv, 0);
    obs_q.push_back(int'(sv));
  endtask

  task automatic rd_byte(input logic [7:0] expv, input logic mack);
    logic [7:0] v;
    logic sv;
    exp_q.push_back('{1, int'(expv)});
    for (int i = 7; i >= 0; i--) begin
      bitx(1'b1, sv, 0);
      v[i] = sv;
    end
    obs_q.push_back(int'(v));
    bitx(mack, sv, 0);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0;
    wt(H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    wt(Q);
    sda_m = 1'b1;
    wt(Q);
    scl_m = 1'b1;
    wt(Q);
    sda_m = 1'b0;
    wt(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wt(Q);
    sda_m = 1'b0;
    wt(Q);
    scl_m = 1'b1;
    wt(Q);
    sda_m = 1'b1;
    wt(H);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    hw_we = 1'b0;
    hw_addr = '0;
    hw_data = '0;
    wt(5);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_strobe", int'(wr_strobe), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_collision", int'(hw_collision), 0);
    chk("rst_regs", int'(regs_flat == '0), 1);
    rst = 1'b0;
    wt(10);

    // plain write with auto-increment
    i2c_start();
    wr_byte(8'hE0, 0);
    chk("busy_match", int'(busy), 1);
    wr_byte(8'd10, 0);
    exp_wr_q.push_back('{10, 'h55});
    wr_byte(8'h55, 0);
    exp_wr_q.push_back('{11, 'h1F});
    wr_byte(8'h1F, 0);
    i2c_stop();
    chk("busy_after_stop", int'(busy), 0);
    chk("reg10", reg_at(10), 'h55);
    chk("reg11", reg_at(11), 'h1F);

    // wrong address
    watch = 1;
    i2c_start();
    wr_byte(8'hE2, 1);
    wr_byte(8'h00, 1);
    wr_byte(8'hAA, 1);
    i2c_stop();
    watch = 0;
    chk("wrong_oe", int'(oe_seen), 0);
    chk("wrong_busy", int'(busy_seen), 0);
    chk("wrong_reg0", reg_at(0), 0);
    chk("wrong_reg10", reg_at(10), 'h55);

    // set pointer, repeated START, read two bytes
    i2c_start();
    wr_byte(8'hE0, 0);
    wr_byte(8'd10, 0);
    i2c_rstart();
    wr_byte(8'hE1, 0);
    rd_byte(8'h55, 1'b0);
    rd_byte(8'h1F, 1'b1);
    i2c_stop();
    chk("busy_after_rd", int'(busy), 0);

    // wrap from last register to 0, then out-of-range sub-address
    i2c_start();
    wr_byte(8'hE0, 0);
    wr_byte(8'd15, 0);
    exp_wr_q.push_back('{15, 'h11});
    wr_byte(8'h11, 0);
    exp_wr_q.push_back('{0, 'h22});
    wr_byte(8'h22, 0);
    i2c_stop();
    chk("reg15", reg_at(15), 'h11);
    chk("reg0_wrap", reg_at(0), 'h22);
    i2c_start();
    wr_byte(8'hE0, 0);
    wr_byte(8'd16, 1);
    wr_byte(8'h33, 1);
    i2c_stop();
    chk("reg0_kept", reg_at(0), 'h22);
    chk("reg1_kept", reg_at(1), 0);

    // host writes on the commit edge
    i2c_start();
    wr_byte(8'hE0, 0);
    wr_byte(8'd11, 0);
    col_a = 4'd11;
    col_d = 8'hEE;
    exp_wr_q.push_back('{11, 'h77});
    wr_byte(8'h77, 0, 2, 0);
    col_a = 4'd3;
    col_d = 8'h3C;
    exp_wr_q.push_back('{12, 'h88});
    wr_byte(8'h88, 0, 2, 0);
    i2c_stop();
    chk("col_reg11", reg_at(11), 'h77);
    chk("col_reg12", reg_at(12), 'h88);
    chk("col_reg3", reg_at(3), 'h3C);
    chk("col_pulses", col_seen, 1);

    // reset while driving read data (regs[13] = 0)
    i2c_start();
    wr_byte(8'hE1, 0);
    for (int i = 0; i < 3; i++) bitx(1'b1, s, 0);
    wt(Q);
    chk("oe_before_rst", int'(sda_oe), 1);
    rst = 1'b1;
    wt(1);
    chk("oe_after_rst", int'(sda_oe), 0);
    chk("regs_after_rst", int'(regs_flat == '0), 1);
    chk("busy_after_rst", int'(busy), 0);
    rst = 1'b0;
    i2c_stop();

    // SDA glitches: mid data bit, and on an idle bus
    i2c_start();
    wr_byte(8'hE0, 0);
    wr_byte(8'd5, 0);
    exp_wr_q.push_back('{5, 'hFF});
    wr_byte(8'hFF, 0, 1, 3);
    i2c_stop();
    chk("glitch_reg5", reg_at(5), 'hFF);
    sda_m = 1'b0;
    wt(2);
    sda_m = 1'b1;
    wt(H);
    scl_m = 1'b0;
    wr_byte(8'hE0, 1);
    i2c_stop();
    chk("no_false_busy", int'(busy), 0);

    wt(20);
    chk("bus_q_drained", exp_q.size(), 0);
    chk("wr_q_drained", exp_wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
